gpr_commit_serializer: RTL and testbench

Upstream feeder for the DPI-C GPR update stage. Collects up to two retired GPR writebacks per cycle from a dual-lane commit port and drops writes to x0 or with wen low. Buffers the rest in program order in a small FIFO. Presents at most one write per cycle (out_wen/out_id/out_wdata) to the difftest GPR update sink, with optional stall from the sink side.

---
 rtl/gpr_commit_serializer_if.sv | 29 ++
 rtl/gpr_commit_serializer.sv | 94 +++++++++
 tb/tb_gpr_commit_serializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_commit_serializer_if.sv
// Dual-lane GPR commit port plus single-write sink port for the commit serializer.
// The master drives commit groups and sink ready; the slave is the serializer.
interface gpr_commit_serializer_if #(
  parameter int ID_W       = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wen0;
  logic [ID_W-1:0]       in_id0;
  logic [DATA_WIDTH-1:0] in_wdata0;
  logic                  in_wen1;
  logic [ID_W-1:0]       in_id1;
  logic [DATA_WIDTH-1:0] in_wdata1;
  logic                  out_ready;
  logic                  out_wen;
  logic [ID_W-1:0]       out_id;
  logic [DATA_WIDTH-1:0] out_wdata;

  modport master (
    output in_valid, in_wen0, in_id0, in_wdata0, in_wen1, in_id1, in_wdata1, out_ready,
    input  in_ready, out_wen, out_id, out_wdata
  );

  modport slave (
    input  in_valid, in_wen0, in_id0, in_wdata0, in_wen1, in_id1, in_wdata1, out_ready,
    output in_ready, out_wen, out_id, out_wdata
  );
endinterface

// File: rtl/gpr_commit_serializer.sv
// Serializes up to two retired GPR writebacks per cycle into one write per cycle,
// dropping x0 and disabled lanes and keeping program order in a small FIFO.
module gpr_commit_serializer #(
  parameter int GPR_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  gpr_commit_serializer_if.slave bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            commit_cnt,
  output logic                   proto_err
);

  localparam int ID_W  = $clog2(GPR_NUM);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] wrPtrPlus1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      commitCnt_q, commitCnt_d;
  logic             protoErr_q, protoErr_d;

  logic       inReady;
  logic       accept;
  logic       keep0;
  logic       keep1;
  logic       pop;
  logic       outWen;
  logic [1:0] keptCnt;

  // Two free slots are required so a dual group always fits; a same-cycle pop is ignored
  // on purpose to keep out_ready off the in_ready path.
  assign inReady    = (count_q <= CNT_W'(DEPTH - 2));
  assign accept     = bus.in_valid && inReady;
  assign keep0      = bus.in_wen0 && (bus.in_id0 != '0);
  assign keep1      = bus.in_wen1 && (bus.in_id1 != '0);
  assign keptCnt    = accept ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;
  assign outWen     = (count_q != '0);
  assign pop        = outWen && bus.out_ready;
  assign wrPtrPlus1 = wrPtr_q + PTR_W'(1);

  always_comb begin
    rdPtr_d     = rdPtr_q + PTR_W'(pop);
    wrPtr_d     = wrPtr_q + PTR_W'(keptCnt);
    count_d     = count_q + CNT_W'(keptCnt) - CNT_W'(pop);
    commitCnt_d = commitCnt_q + 32'(pop);
    protoErr_d  = protoErr_q || (bus.in_valid && !inReady);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      commitCnt_q <= '0;
      protoErr_q  <= 1'b0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      commitCnt_q <= commitCnt_d;
      protoErr_q  <= protoErr_d;
    end
  end

  // Lane1 lands behind lane0 only when lane0 was kept, so same-id pairs drain older-first.
  always_ff @(posedge clk) begin
    if (accept && keep0) begin
      mem_q[wrPtr_q] <= '{id: bus.in_id0, data: bus.in_wdata0};
    end
    if (accept && keep1) begin
      mem_q[keep0 ? wrPtrPlus1 : wrPtr_q] <= '{id: bus.in_id1, data: bus.in_wdata1};
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_wen   = outWen;
  assign bus.out_id    = outWen ? mem_q[rdPtr_q].id   : '0;
  assign bus.out_wdata = outWen ? mem_q[rdPtr_q].data : '0;
  assign count         = count_q;
  assign commit_cnt    = commitCnt_q;
  assign proto_err     = protoErr_q;

endmodule

// File: tb/tb_gpr_commit_serializer.sv
// Self-checking bench for gpr_commit_serializer: table-driven vectors plus a scoreboard
// queue of expected sink writes, filled as commit groups are driven.
module tb_gpr_commit_serializer;

  localparam int DEPTH = 8;
  localparam int ID_W  = 5;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_commit_serializer_if #(.ID_W(ID_W), .DATA_WIDTH(DW)) bus ();
  logic [CW-1:0] count;
  logic [31:0]   commit_cnt;
  logic          proto_err;

  gpr_commit_serializer #(.GPR_NUM(32), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .commit_cnt (commit_cnt),
    .proto_err  (proto_err)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
  } ent_t;

  typedef struct {
    logic            valid;
    logic            wen0;
    logic [ID_W-1:0] id0;
    logic [DW-1:0]   d0;
    logic            wen1;
    logic [ID_W-1:0] id1;
    logic [DW-1:0]   d1;
    logic            outReady;
    logic            expWen;
    logic [ID_W-1:0] expId;
    logic [DW-1:0]   expData;
    int              expCount;
  } vec_t;

  ent_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          expCount = 0;
  int unsigned expCommit = 0;
  logic        expProto = 1'b0;
  logic        sawNotReady = 1'b0;
  logic            smpWen;
  logic [ID_W-1:0] smpId;
  logic [DW-1:0]   smpData;
  logic [CW-1:0]   smpCount;
  vec_t        table_v[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic wen0, input logic [ID_W-1:0] id0,
                              input logic [DW-1:0] d0, input logic wen1, input logic [ID_W-1:0] id1,
                              input logic [DW-1:0] d1, input logic outReady);
    vec_t v;
    v.valid = valid; v.wen0 = wen0; v.id0 = id0; v.d0 = d0;
    v.wen1 = wen1; v.id1 = id1; v.d1 = d1; v.outReady = outReady;
    v.expWen = 1'b0; v.expId = '0; v.expData = '0; v.expCount = 0;
    return v;
  endfunction

  function automatic vec_t idle(input logic outReady);
    return mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, outReady);
  endfunction

  // One clock: drive at posedge+1, compare at negedge, advance the model after the edge.
  task automatic applyStimulus(input vec_t v);
    logic expReady;
    int   kept;
    int   popped;
    ent_t head;
    bus.in_valid  = v.valid;
    bus.in_wen0   = v.wen0;  bus.in_id0 = v.id0;  bus.in_wdata0 = v.d0;
    bus.in_wen1   = v.wen1;  bus.in_id1 = v.id1;  bus.in_wdata1 = v.d1;
    bus.out_ready = v.outReady;
    expReady = ((DEPTH - expCount) >= 2);
    kept = 0;
    popped = 0;
    if (v.valid && expReady) begin
      if (v.wen0 && v.id0 != '0) begin sb.push_back('{id: v.id0, data: v.d0}); kept++; end
      if (v.wen1 && v.id1 != '0) begin sb.push_back('{id: v.id1, data: v.d1}); kept++; end
    end
    @(negedge clk);
    smpWen = bus.out_wen; smpId = bus.out_id; smpData = bus.out_wdata; smpCount = count;
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("count", count, expCount);
    checkOutput("out_wen", bus.out_wen, expCount != 0);
    checkOutput("commit_cnt", commit_cnt, expCommit);
    checkOutput("proto_err", proto_err, expProto);
    if (expCount != 0) begin
      head = sb[0];
      checkOutput("out_id", bus.out_id, head.id);
      checkOutput("out_wdata", bus.out_wdata, head.data);
      if (v.outReady) begin
        void'(sb.pop_front());
        popped = 1;
      end
    end else begin
      checkOutput("out_id_idle", bus.out_id, 0);
      checkOutput("out_wdata_idle", bus.out_wdata, 0);
    end
    if (!expReady) sawNotReady = 1'b1;
    @(posedge clk);
    #1;
    expCount  = expCount + kept - popped;
    expCommit = expCommit + popped;
    if (v.valid && !expReady) expProto = 1'b1;
  endtask

  task automatic doReset(input int cycles);
    bus.in_valid = 1'b0; bus.in_wen0 = 1'b0; bus.in_wen1 = 1'b0;
    bus.in_id0 = '0; bus.in_id1 = '0; bus.in_wdata0 = '0; bus.in_wdata1 = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    expCount = 0;
    expCommit = 0;
    expProto = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int n;

    table_v[0] = mk(1, 1, 5, 32'hA5A5_0001, 1, 7, 32'h0000_0BEE, 1);
    table_v[1] = idle(1); table_v[1].expWen = 1; table_v[1].expId = 5;
    table_v[1].expData = 32'hA5A5_0001; table_v[1].expCount = 2;
    table_v[2] = idle(1); table_v[2].expWen = 1; table_v[2].expId = 7;
    table_v[2].expData = 32'h0000_0BEE; table_v[2].expCount = 1;
    table_v[3] = mk(1, 1, 0, 32'hDEAD_0000, 0, 3, 32'h0000_BEEF, 1);
    table_v[4] = mk(1, 0, 4, 32'h1234_0000, 1, 0, 32'h0000_5678, 1);
    table_v[5] = idle(1);
    table_v[6] = idle(1);

    doReset(3);
    applyStimulus(idle(1));
    checkOutput("reset_in_ready", smpCount == 0 && bus.in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(table_v[i]);
      checkOutput($sformatf("tbl%0d_wen", i), smpWen, table_v[i].expWen);
      checkOutput($sformatf("tbl%0d_id", i), smpId, table_v[i].expId);
      checkOutput($sformatf("tbl%0d_data", i), smpData, table_v[i].expData);
      checkOutput($sformatf("tbl%0d_count", i), smpCount, table_v[i].expCount);
    end
    checkOutput("dual_commit_cnt", commit_cnt, 2);

    doReset(1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mk(1, 1, ID_W'(2*k+1), DW'(2*k+1), 1, ID_W'(2*k+2), DW'(2*k+2), 0));
    end
    applyStimulus(mk(1, 1, 9, 9, 1, 10, 10, 0));
    checkOutput("bp_full_count", smpCount, 8);
    checkOutput("bp_proto", proto_err, 1);
    for (int c = 0; c < 10; c++) applyStimulus(idle(1));
    checkOutput("bp_commit_cnt", commit_cnt, 8);
    checkOutput("bp_empty", count, 0);

    doReset(1);
    sent = 0;
    sawNotReady = 1'b0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      if (expCount <= DEPTH - 2) begin
        n = 2 * sent;
        applyStimulus(mk(1, 1, ID_W'((n % 31) + 1), $urandom,
                         1, ID_W'(((n + 1) % 31) + 1), $urandom, 1));
        sent++;
      end else begin
        applyStimulus(idle(1));
      end
    end
    if (sent < 20) checkOutput("wrap_send_timeout", sent, 20);
    for (int c = 0; c < 50 && expCount != 0; c++) applyStimulus(idle(1));
    if (expCount != 0) checkOutput("wrap_drain_timeout", count, 0);
    checkOutput("wrap_commit_cnt", commit_cnt, 40);
    checkOutput("wrap_saw_not_ready", sawNotReady, 1);
    checkOutput("wrap_proto", proto_err, 0);

    doReset(1);
    applyStimulus(mk(1, 1, 9, 32'h11, 1, 9, 32'h22, 1));
    applyStimulus(idle(1));
    checkOutput("same_id_first", smpData, 32'h11);
    applyStimulus(idle(1));
    checkOutput("same_id_second", smpData, 32'h22);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk(1, 1, ID_W'(10 + 2*k), DW'(100 + k), 1, ID_W'(11 + 2*k), DW'(200 + k), 0));
    end
    checkOutput("fill_count", count, 6);
    doReset(1);
    checkOutput("mid_reset_count", count, 0);
    checkOutput("mid_reset_wen", bus.out_wen, 0);
    checkOutput("mid_reset_commit", commit_cnt, 0);
    for (int c = 0; c < 4; c++) applyStimulus(idle(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
